// File: rtl/lsu_align.sv
// Load/store alignment unit between execute and a word-wide single-cycle data RAM.
// Sub-word stores are read-modify-write; misaligned or illegal-size accesses trap without RAM traffic.
module lsu_align #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             ram_valid,
  output logic             ram_wen,
  output logic [31:0]      ram_rlen,
  output logic [31:0]      ram_raddr,
  output logic [31:0]      ram_waddr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [DW-1:0]    resp_rdata_q;
  logic             ram_valid_q;
  logic             ram_wen_q;
  logic [DW-1:0]    ram_raddr_q;
  logic [DW-1:0]    ram_waddr_q;
  logic [DW-1:0]    ram_wdata_q;
  logic [CNT_W-1:0] load_cnt_q;
  logic [CNT_W-1:0] store_cnt_q;

  // Latched request fields; only the in-word offset of the address is needed after accept.
  logic             wen_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;
  logic [DW-1:0]    wdata_q;

  function automatic logic acc_err(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] word,
                                             input logic [1:0]    off,
                                             input logic [1:0]    size,
                                             input logic          uns);
    logic [DW-1:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_ext = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: load_ext = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  endfunction

  // Replace the addressed byte (or half selected by off[1]) of the read word with low store data.
  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                input logic [DW-1:0] wdata,
                                                input logic [1:0]    off,
                                                input logic [1:0]    size);
    logic [4:0]    sh;
    logic [DW-1:0] mask;
    if (size == SZ_BYTE) begin
      sh   = {off, 3'b000};
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = {off[1], 4'b0000};
      mask = 32'h0000_FFFF << sh;
    end
    return (word & ~mask) | ((wdata << sh) & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_valid_q  <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_raddr_q  <= '0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      wen_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            wen_q       <= req_wen;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            off_q       <= req_addr[1:0];
            wdata_q     <= req_wdata;
            if (acc_err(req_size, req_addr[1:0])) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!req_wen || (req_size != SZ_WORD)) begin
              state_q     <= S_RD;
              ram_valid_q <= 1'b1;
              ram_raddr_q <= {req_addr[31:2], 2'b00};
              ram_waddr_q <= {req_addr[31:2], 2'b00};
            end else begin
              state_q     <= S_WR;
              ram_wen_q   <= 1'b1;
              ram_raddr_q <= {req_addr[31:2], 2'b00};
              ram_waddr_q <= {req_addr[31:2], 2'b00};
              ram_wdata_q <= req_wdata;
            end
          end
        end

        // RAM data is combinational, so extension/merge happen on the read edge itself.
        S_RD: begin
          ram_valid_q <= 1'b0;
          if (!wen_q) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= load_ext(ram_rdata, off_q, size_q, uns_q);
            ram_raddr_q  <= '0;
            ram_waddr_q  <= '0;
          end else begin
            state_q     <= S_WR;
            ram_wen_q   <= 1'b1;
            ram_wdata_q <= store_merge(ram_rdata, wdata_q, off_q, size_q);
          end
        end

        S_WR: begin
          state_q      <= S_RESP;
          ram_wen_q    <= 1'b0;
          ram_raddr_q  <= '0;
          ram_waddr_q  <= '0;
          ram_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end

        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (!resp_err_q) begin
              if (wen_q) store_cnt_q <= store_cnt_q + CNT_W'(1);
              else       load_cnt_q  <= load_cnt_q + CNT_W'(1);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM strobes are masked by reset so an in-flight access cannot fire during the reset cycle.
  assign ram_valid  = ram_valid_q & ~rst;
  assign ram_wen    = ram_wen_q & ~rst;
  assign ram_rlen   = 32'd4;
  assign ram_raddr  = ram_raddr_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign load_cnt   = load_cnt_q;
  assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: vector table through a response scoreboard, plus hand-written
// sequences for response back-pressure and reset in the middle of a read-modify-write.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_valid;
  logic        ram_wen;
  logic [31:0] ram_rlen;
  logic [31:0] ram_raddr;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic        wen;
  } exp_t;

  vec_t        vt[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_lc = 0;
  int          exp_sc = 0;
  logic [31:0] mem [0:63];

  lsu_align #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .ram_valid(ram_valid), .ram_wen(ram_wen), .ram_rlen(ram_rlen),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  // Word RAM model: combinational read, write on the clock edge.
  assign ram_rdata = mem[ram_raddr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899_AABB;
      mem[5] <= 32'h1122_3344;
    end else if (ram_wen) begin
      mem[ram_waddr[7:2]] <= ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_wen      = v.wen;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.lat   = v.exp_lat;
    e.nrd   = (!v.exp_err && (!v.wen || v.size < 2'd2)) ? 1 : 0;
    e.nwr   = (!v.exp_err && v.wen) ? 1 : 0;
    e.waddr = {v.addr[31:2], 2'b00};
    e.wen   = v.wen;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; waits for the response, optionally stalls it, then handshakes.
  task automatic collect(input int hold, input bit poke);
    exp_t e;
    int   lat;
    int   nrd;
    int   nwr;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    lat = 1; nrd = 0; nwr = 0;
    while (!resp_valid && lat < 8) begin
      chk("ram_exclusive", 32'(ram_valid & ram_wen), 32'd0);
      if (ram_valid) begin
        nrd++;
        chk("ram_raddr", ram_raddr, sb[0].waddr);
      end
      if (ram_wen) begin
        nwr++;
        chk("ram_waddr", ram_waddr, sb[0].waddr);
      end
      @(posedge clk); #1; lat++;
    end
    chk("resp_valid_timeout", 32'(resp_valid), 32'd1);
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("ram_reads", 32'(nrd), 32'(e.nrd));
    chk("ram_writes", 32'(nwr), 32'(e.nwr));
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_err", 32'(resp_err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010; req_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, e.rdata);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_ram_valid", 32'(ram_valid), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (!e.err) begin
      if (e.wen) exp_sc++;
      else       exp_lc++;
    end
    chk("post_hs_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    chk("load_cnt", load_cnt, 32'(exp_lc));
    chk("store_cnt", store_cnt, 32'(exp_sc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // wen, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h8000_0011, 32'h0,         32'hFFFF_FFAA, 1'b0, 2});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0,         32'h0000_8899, 1'b0, 2});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,         32'hFFFF_8899, 1'b0, 2});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0,         32'h0000_0088, 1'b0, 2});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h8899_AABB, 1'b0, 2});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h8000_0010, 32'h0,         32'hFFFF_FFBB, 1'b0, 2});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h8000_0010, 32'h0,         32'hFFFF_AABB, 1'b0, 2});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h8000_0014, 32'h0,         32'h0000_0044, 1'b0, 2});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h8000_0017, 32'h0,         32'h0000_0011, 1'b0, 2});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_1234, 32'h0,         1'b0, 3});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h1234_AABB, 1'b0, 2});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h8000_0015, 32'hFFFF_FF5A, 32'h0,         1'b0, 3});
    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h8000_0015, 32'h0,         32'h0000_005A, 1'b0, 2});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h8000_0018, 32'hDEAD_BEEF, 32'h0,         1'b0, 2});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0018, 32'h0,         32'hDEAD_BEEF, 1'b0, 2});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,         32'h0,         1'b1, 1});
    vt.push_back('{1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1, 1});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h8000_0011, 32'h0,         32'h0,         1'b1, 1});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h8000_0013, 32'h0000_FFFF, 32'h0,         1'b1, 1});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h8000_0016, 32'h0000_CAFE, 32'h0,         1'b1, 1});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h8000_0016, 32'h0,         32'h0000_1122, 1'b0, 2});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_valid", 32'(ram_valid), 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_ram_rlen", ram_rlen, 32'd4);
    chk("rst_load_cnt", load_cnt, 32'd0);
    chk("rst_store_cnt", store_cnt, 32'd0);

    foreach (vt[i]) begin
      issue(vt[i]);
      collect(0, 1'b0);
    end

    // Word store with the response stalled while another request is offered.
    v = '{1'b1, 2'd2, 1'b0, 32'h8000_001C, 32'h0BAD_F00D, 32'h0, 1'b0, 2};
    issue(v);
    collect(3, 1'b1);

    // Reset lands while a byte store is in its read cycle.
    v = '{1'b1, 2'd0, 1'b0, 32'h8000_0010, 32'h0000_0077, 32'h0, 1'b0, 3};
    issue(v);
    chk("rmw_in_rd", 32'(ram_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_forces_ram_valid", 32'(ram_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    exp_lc = 0;
    exp_sc = 0;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_load_cnt", load_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_write", 32'(ram_wen), 32'd0);
      @(posedge clk); #1;
    end
    chk("midrst_mem_word", mem[4], 32'h1234_AABB);
    v = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 32'h1234_AABB, 1'b0, 2};
    issue(v);
    collect(0, 1'b0);

    chk("mem_word5", mem[5], 32'h1122_5A44);
    chk("mem_word6", mem[6], 32'hDEAD_BEEF);
    chk("mem_word7", mem[7], 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
